// File: rtl/lut_sxx_config_loader.sv
// Configuration sequencer for a chained LUT pair: collects MSB-first stream words into a
// shadow register and commits the full image to config_out with a one-cycle cen strobe.
module lut_sxx_config_loader #(
  parameter int INPUTS   = 4,
  parameter int MEM_SIZE = 2 ** INPUTS,
  parameter int CFG_BITS = 2 * MEM_SIZE,
  parameter int WORD_W   = 8
) (
  input  logic                cclk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [WORD_W-1:0]   cfg_word,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [CFG_BITS-1:0] config_out,
  output logic                cen,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int NWORDS = CFG_BITS / WORD_W;
  localparam int CNT_W  = $clog2(NWORDS) + 1;

  if ((CFG_BITS % WORD_W) != 0) begin : g_bad_word_width
    $error("lut_sxx_config_loader: CFG_BITS must be a multiple of WORD_W");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] config_q, config_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                cen_q, cen_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                handshake;

  assign handshake = cfg_valid && cfg_ready_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case leaves
    // one unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    config_d = config_q;
    done_d   = done_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      S_LOAD: begin
        // Abort outranks a same-cycle handshake; the word in flight is dropped.
        if (abort) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (handshake) begin
          shadow_d = {shadow_q[CFG_BITS-WORD_W-1:0], cfg_word};
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NWORDS - 1)) begin
            config_d = shadow_d;
            state_d  = S_COMMIT;
          end
        end
      end

      S_COMMIT: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of what the next state implies.
    cfg_ready_d = (state_d == S_LOAD);
    cen_d       = (state_d == S_COMMIT);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      config_q    <= '0;
      cfg_ready_q <= 1'b0;
      cen_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent
      // of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      config_q    <= config_d;
      cfg_ready_q <= cfg_ready_d;
      cen_q       <= cen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign config_out = config_q;
  assign cen        = cen_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lut_sxx_config_loader.sv
// Directed bench for lut_sxx_config_loader: a transaction-level model checked every cycle,
// plus literal expectations for the images, flags and strobe timing.
module tb_lut_sxx_config_loader;

  localparam int WORD_W   = 8;
  localparam int CFG_BITS = 32;
  localparam int NWORDS   = CFG_BITS / WORD_W;

  logic                cclk = 1'b0;
  logic                rst, start, abort, cfg_valid;
  logic [WORD_W-1:0]   cfg_word;
  logic                cfg_ready, cen, busy, done, err;
  logic [CFG_BITS-1:0] config_out;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int cen_cnt = 0;
  int last_cen_cyc = 0;
  int start_cyc = 0;

  lut_sxx_config_loader #(.INPUTS(4), .WORD_W(WORD_W)) dut (
    .cclk(cclk), .rst(rst), .start(start), .abort(abort),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .config_out(config_out), .cen(cen), .busy(busy), .done(done), .err(err)
  );

  always #5 cclk = ~cclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: a phase (idle / collecting / committing) and a word queue.
  bit                  m_ok = 0;
  bit                  m_collecting, m_committing, m_done, m_err;
  logic [CFG_BITS-1:0] m_cfg;
  logic [WORD_W-1:0]   m_words[$];

  always @(posedge cclk) begin
    cyc++;
    if (rst) begin
      m_ok = 1; m_collecting = 0; m_committing = 0; m_done = 0; m_err = 0;
      m_cfg = '0; m_words.delete();
    end else if (m_ok) begin
      if (m_committing) begin
        m_committing = 0;
        m_done = 1;
      end else if (m_collecting) begin
        if (abort) begin
          m_collecting = 0;
          m_err = 1;
          m_words.delete();
        end else if (cfg_valid) begin
          m_words.push_back(cfg_word);
          if (m_words.size() == NWORDS) begin
            m_cfg = '0;
            foreach (m_words[i]) m_cfg = (m_cfg << WORD_W) | CFG_BITS'(m_words[i]);
            m_words.delete();
            m_collecting = 0;
            m_committing = 1;
          end
        end
      end else if (start && !abort) begin
        m_collecting = 1;
        m_done = 0;
        m_err = 0;
        m_words.delete();
      end
    end
    #1;
    if (m_ok) begin
      check("cfg_ready", 64'(cfg_ready), 64'(m_collecting));
      check("cen", 64'(cen), 64'(m_committing));
      check("busy", 64'(busy), 64'(m_collecting | m_committing));
      check("done", 64'(done), 64'(m_done));
      check("err", 64'(err), 64'(m_err));
      check("config_out", 64'(config_out), 64'(m_cfg));
      if (cen === 1'b1) begin
        cen_cnt++;
        last_cen_cyc = cyc;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge cclk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input int gap);
    bit got;
    cfg_valid = 1'b0;
    repeat (gap) @(negedge cclk);
    cfg_word  = w;
    cfg_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (cfg_ready) got = 1;
      @(negedge cclk);
    end
    if (!got) check("ready_timeout", 64'd0, 64'd1);
    cfg_valid = 1'b0;
  endtask

  task automatic do_load(input logic [CFG_BITS-1:0] img, input int gap);
    pulse_start();
    for (int k = 0; k < NWORDS; k++) send_word(img[CFG_BITS-1-WORD_W*k -: WORD_W], gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_word = '0;
    repeat (2) @(negedge cclk);
    check("reset_config", 64'(config_out), 64'h0);
    check("reset_flags", 64'({cfg_ready, cen, busy, done, err}), 64'h0);
    rst = 1'b0;
    @(negedge cclk);

    // 1: continuous valid
    c0 = cen_cnt;
    do_load(32'hDEADBEEF, 0);
    check("t1_cen_latency", 64'(last_cen_cyc - start_cyc), 64'(NWORDS));
    check("t1_config", 64'(config_out), 64'hDEADBEEF);
    @(negedge cclk);
    check("t1_done_busy", 64'({done, busy}), 64'b10);
    check("t1_cen_count", 64'(cen_cnt - c0), 64'd1);

    // 2: three idle cycles between words
    c0 = cen_cnt;
    do_load(32'hDEADBEEF, 3);
    @(negedge cclk);
    check("t2_config", 64'(config_out), 64'hDEADBEEF);
    check("t2_done", 64'(done), 64'd1);
    check("t2_cen_count", 64'(cen_cnt - c0), 64'd1);

    // 3: abort after two words
    c0 = cen_cnt;
    pulse_start();
    send_word(8'h12, 0);
    send_word(8'h34, 0);
    abort = 1'b1;
    @(negedge cclk);
    abort = 1'b0;
    @(negedge cclk);
    check("t3_err_done", 64'({err, done, busy}), 64'b100);
    check("t3_config", 64'(config_out), 64'hDEADBEEF);
    check("t3_no_cen", 64'(cen_cnt - c0), 64'd0);

    // 4: start pulses in LOAD and COMMIT are ignored
    c0 = cen_cnt;
    pulse_start();
    send_word(8'h11, 0);
    start = 1'b1;
    send_word(8'h22, 0);
    start = 1'b0;
    send_word(8'h33, 0);
    send_word(8'h44, 0);
    start = 1'b1;
    @(negedge cclk);
    start = 1'b0;
    @(negedge cclk);
    check("t4_config", 64'(config_out), 64'h11223344);
    check("t4_idle", 64'({busy, done, err}), 64'b010);
    check("t4_cen_count", 64'(cen_cnt - c0), 64'd1);

    // 5: reset mid-load
    c0 = cen_cnt;
    pulse_start();
    send_word(8'hA1, 0);
    send_word(8'hA2, 0);
    rst = 1'b1;
    @(negedge cclk);
    rst = 1'b0;
    check("t5_reset_config", 64'(config_out), 64'h0);
    check("t5_reset_flags", 64'({cfg_ready, cen, busy, done, err}), 64'h0);
    check("t5_no_cen", 64'(cen_cnt - c0), 64'd0);
    do_load(32'h01020304, 0);
    @(negedge cclk);
    check("t5_config", 64'(config_out), 64'h01020304);

    // 6: back-to-back loads, second start in the first IDLE cycle
    c0 = cen_cnt;
    do_load(32'hAA55AA55, 0);
    check("t6_first_config", 64'(config_out), 64'hAA55AA55);
    @(negedge cclk);
    do_load(32'h0F0F0F0F, 0);
    @(negedge cclk);
    check("t6_second_config", 64'(config_out), 64'h0F0F0F0F);
    check("t6_cen_count", 64'(cen_cnt - c0), 64'd2);

    repeat (2) @(negedge cclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
